// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA control-bus multiplexer: bit positions, the
// released word and the scan FSM states.
package jamma_pkg;

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int FIRE1 = 4;
  localparam int FIRE2 = 5;
  localparam int FIRE3 = 6;
  localparam int START = 7;

  localparam logic [7:0] JOY_RELEASED = 8'hFF;

  typedef enum logic [0:0] {
    ST_WAIT   = 1'b0,
    ST_SAMPLE = 1'b1
  } state_t;

  // A select bus needs at least one wire, even for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jamma_joy_mux_if.sv
// Bus bundle between the arcade core and the JAMMA multiplexer; the core side
// uses the master modport and the multiplexer uses the slave modport.
interface jamma_joy_mux_if
  import jamma_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 8
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic                      I_ENA;
  logic [WIDTH-1:0]          I_JOY;
  logic [NUM_CH*WIDTH-1:0]   I_MASK;
  logic [SEL_W-1:0]          O_SEL;
  logic [NUM_CH*WIDTH-1:0]   O_JOY;
  logic [NUM_CH-1:0]         O_VALID;
  logic                      O_FRAME;

  modport master (
    output I_ENA, I_JOY, I_MASK,
    input  O_SEL, O_JOY, O_VALID, O_FRAME
  );

  modport slave (
    input  I_ENA, I_JOY, I_MASK,
    output O_SEL, O_JOY, O_VALID, O_FRAME
  );

endinterface

// File: rtl/jamma_debounce.sv
// Per-channel scan debouncer: a word is accepted once it has been seen on
// DEB_SCANS consecutive samples of that channel.
module jamma_debounce #(
  parameter int WIDTH     = 8,
  parameter int DEB_SCANS = 2
) (
  input  logic             I_CLK,
  input  logic             I_RESET_N,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             valid_o
);

  localparam logic [2:0] CNT_MAX = 3'(DEB_SCANS - 1);

  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;

  // A differing sample restarts the run; an agreeing one saturates at CNT_MAX.
  always_comb begin
    last_d   = last_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    if (sample_i) begin
      if (raw_i != last_q) begin
        last_d = raw_i;
        cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 3'd1;
      end
      if (cnt_d == CNT_MAX) begin
        stable_d = raw_i;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      last_q   <= '1;
      stable_q <= '1;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign stable_o = stable_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/jamma_joy_mux.sv
// N-channel time multiplexer for the shared JAMMA input bus: steps the select
// lines, waits for the external mux to settle, samples and debounces each channel.
module jamma_joy_mux
  import jamma_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int DEB_SCANS     = 2
) (
  input  logic            I_CLK,
  input  logic            I_RESET_N,
  jamma_joy_mux_if.slave  bus
);

  localparam int               SEL_W       = sel_width(NUM_CH);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_CH - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  // With no settle time the scan lives permanently in SAMPLE.
  localparam state_t           ST_START    = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_WAIT;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             frame_q, frame_d;
  logic             sample_now;

  logic [NUM_CH-1:0] strobe;
  logic [WIDTH-1:0]  stable [NUM_CH];
  logic [NUM_CH-1:0] valid;

  assign sample_now = bus.I_ENA && (state_q == ST_SAMPLE);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    frame_d  = sample_now && (sel_q == SEL_LAST);
    if (bus.I_ENA) begin
      case (state_q)
        ST_WAIT: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = ST_SAMPLE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        ST_SAMPLE: begin
          sel_d    = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          settle_d = '0;
          state_d  = ST_START;
        end
        default: state_d = ST_START;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q  <= ST_START;
      settle_q <= '0;
      sel_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
    end
  end

  // Each channel is sampled only while the select lines point at it.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign strobe[c] = sample_now && (sel_q == SEL_W'(c));

    jamma_debounce #(
      .WIDTH     (WIDTH),
      .DEB_SCANS (DEB_SCANS)
    ) u_deb (
      .I_CLK     (I_CLK),
      .I_RESET_N (I_RESET_N),
      .sample_i  (strobe[c]),
      .raw_i     (bus.I_JOY),
      .stable_o  (stable[c]),
      .valid_o   (valid[c])
    );

    assign bus.O_JOY[c*WIDTH +: WIDTH] = stable[c] & bus.I_MASK[c*WIDTH +: WIDTH];
  end

  assign bus.O_SEL   = sel_q;
  assign bus.O_VALID = valid;
  assign bus.O_FRAME = frame_q;

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Directed bench for jamma_joy_mux: a 2-channel/settle-1 instance and a
// 3-channel/settle-0 instance, each fed from a per-channel mux model.
module tb_jamma_joy_mux;
  import jamma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA_n, rstB_n;
  logic [7:0] chA [0:1];
  logic [7:0] chB [0:3];

  int errors = 0;
  int checks = 0;

  jamma_joy_mux_if #(.NUM_CH(2), .WIDTH(8)) ifA ();
  jamma_joy_mux_if #(.NUM_CH(3), .WIDTH(8)) ifB ();

  // External mux model: the bus carries whichever channel the DUT selects.
  assign ifA.I_JOY = chA[ifA.O_SEL];
  assign ifB.I_JOY = chB[ifB.O_SEL];

  jamma_joy_mux #(.NUM_CH(2), .WIDTH(8), .SETTLE_CYCLES(1), .DEB_SCANS(2)) dutA (
    .I_CLK     (clk),
    .I_RESET_N (rstA_n),
    .bus       (ifA)
  );

  jamma_joy_mux #(.NUM_CH(3), .WIDTH(8), .SETTLE_CYCLES(0), .DEB_SCANS(3)) dutB (
    .I_CLK     (clk),
    .I_RESET_N (rstB_n),
    .bus       (ifB)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ch0B, input int cycles);
    chB[0] = ch0B;
    tick(cycles);
  endtask

  initial begin
    rstA_n     = 1'b0;
    rstB_n     = 1'b0;
    ifA.I_ENA  = 1'b1;
    ifB.I_ENA  = 1'b1;
    ifA.I_MASK = '1;
    ifB.I_MASK = '1;
    chA[0] = JOY_RELEASED;
    chA[1] = 8'hFE;
    chB[0] = JOY_RELEASED;
    chB[1] = JOY_RELEASED;
    chB[2] = JOY_RELEASED;
    chB[3] = 8'h00;
    tick(2);

    checkOutput("A reset sel",   32'(ifA.O_SEL),   32'h0);
    checkOutput("A reset joy",   32'(ifA.O_JOY),   32'hFFFF);
    checkOutput("A reset valid", 32'(ifA.O_VALID), 32'h0);
    checkOutput("A reset frame", 32'(ifA.O_FRAME), 32'h0);
    checkOutput("B reset sel",   32'(ifB.O_SEL),   32'h0);
    checkOutput("B reset joy",   32'(ifB.O_JOY),   32'hFFFFFF);
    checkOutput("B reset valid", 32'(ifB.O_VALID), 32'h0);

    rstA_n = 1'b1;
    tick(1);
    checkOutput("A settle sel", 32'(ifA.O_SEL), 32'h0);
    tick(1);
    checkOutput("A ch0 sampled sel", 32'(ifA.O_SEL),   32'h1);
    checkOutput("A ch0 valid",       32'(ifA.O_VALID), 32'h1);
    tick(1);
    checkOutput("A ch1 settle sel", 32'(ifA.O_SEL), 32'h1);
    tick(1);
    checkOutput("A wrap sel",        32'(ifA.O_SEL),   32'h0);
    checkOutput("A frame pulse 1",   32'(ifA.O_FRAME), 32'h1);
    checkOutput("A ch1 one sample",  32'(ifA.O_JOY),   32'hFFFF);
    checkOutput("A ch1 not valid",   32'(ifA.O_VALID), 32'h1);
    tick(1);
    checkOutput("A frame drop",  32'(ifA.O_FRAME), 32'h0);
    checkOutput("A round2 sel0", 32'(ifA.O_SEL),   32'h0);
    tick(2);
    checkOutput("A round2 sel1", 32'(ifA.O_SEL), 32'h1);
    tick(1);
    checkOutput("A ch1 debounced", 32'(ifA.O_JOY),   32'hFEFF);
    checkOutput("A both valid",    32'(ifA.O_VALID), 32'h3);
    checkOutput("A frame pulse 2", 32'(ifA.O_FRAME), 32'h1);
    checkOutput("A round3 sel",    32'(ifA.O_SEL),   32'h0);

    ifA.I_MASK = 16'hFF7F;
    #1;
    checkOutput("A mask overlay", 32'(ifA.O_JOY), 32'hFE7F);

    ifA.I_ENA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("A frozen sel",   32'(ifA.O_SEL),   32'h0);
      checkOutput("A frozen frame", 32'(ifA.O_FRAME), 32'h0);
    end
    ifA.I_ENA = 1'b1;
    tick(1);
    checkOutput("A resume settle sel", 32'(ifA.O_SEL), 32'h0);
    tick(1);
    checkOutput("A resume sel1", 32'(ifA.O_SEL), 32'h1);

    #2;
    rstA_n = 1'b0;
    #1;
    checkOutput("A async reset sel",   32'(ifA.O_SEL),   32'h0);
    checkOutput("A async reset valid", 32'(ifA.O_VALID), 32'h0);
    checkOutput("A async reset frame", 32'(ifA.O_FRAME), 32'h0);
    checkOutput("A mask in reset",     32'(ifA.O_JOY),   32'hFF7F);
    tick(2);
    rstA_n = 1'b1;
    tick(1);
    checkOutput("A restart settle valid", 32'(ifA.O_VALID), 32'h0);
    checkOutput("A restart settle sel",   32'(ifA.O_SEL),   32'h0);
    tick(1);
    checkOutput("A restart first sample", 32'(ifA.O_VALID), 32'h1);
    checkOutput("A restart sel1",         32'(ifA.O_SEL),   32'h1);

    rstB_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      checkOutput("B sel sequence", 32'(ifB.O_SEL),   32'(k % 3));
      checkOutput("B frame cadence", 32'(ifB.O_FRAME), (k % 3 == 0) ? 32'h1 : 32'h0);
    end
    checkOutput("B all valid", 32'(ifB.O_VALID), 32'h7);
    checkOutput("B idle joy",  32'(ifB.O_JOY),   32'hFFFFFF);

    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 8'hFE : 8'hFF, 3);
      checkOutput("B bounce hold", 32'(ifB.O_JOY[7:0]), 32'hFF);
    end
    applyStimulus(8'hFE, 3);
    checkOutput("B steady 1 hold", 32'(ifB.O_JOY[7:0]), 32'hFF);
    applyStimulus(8'hFE, 3);
    checkOutput("B steady 2 hold", 32'(ifB.O_JOY[7:0]), 32'hFF);
    applyStimulus(8'hFE, 3);
    checkOutput("B steady 3 accept", 32'(ifB.O_JOY), 32'hFFFFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
